// File: rtl/display_mode_scheduler_if.sv
// Keyboard/frame inputs and mux select/blank outputs of display_mode_scheduler.
// The master side (keyboard decoder / vga_sync) drives inputs; the slave side is the scheduler.
interface display_mode_scheduler_if;
  logic [7:0] keyboard_data;
  logic       frame_start;
  logic       mode_sel;
  logic       blank;
  logic       mode_changed;
  logic [1:0] state;

  modport master (
    output keyboard_data, frame_start,
    input  mode_sel, blank, mode_changed, state
  );

  modport slave (
    input  keyboard_data, frame_start,
    output mode_sel, blank, mode_changed, state
  );
endinterface

// File: rtl/display_mode_scheduler.sv
// Auto/manual display mode scheduler: F1 requests switch at a frame boundary, then BLANK_FRAMES blanked frames.
// Outputs registered, one cycle after the causing input; no backpressure. Idle timeout built when MODE_TIMEOUT_EN is defined.
module display_mode_scheduler #(
  parameter int BLANK_FRAMES = 2,
  parameter int IDLE_FRAMES  = 600
) (
  input  logic                     clk,
  input  logic                     reset,
  display_mode_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    PEND   = 2'd2,
    BLANK  = 2'd3
  } state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_FRAMES);

  if (BLANK_FRAMES < 0 || BLANK_FRAMES > 255 || IDLE_FRAMES < 1 || IDLE_FRAMES > 65535) begin : g_bad_param
    $error("display_mode_scheduler: parameter out of range");
  end

  state_t     state_q, state_nxt;
  logic       f1_prev;
  logic       f1_rise;
  logic       target, target_nxt;
  logic [7:0] blank_cnt, blank_cnt_nxt;
  logic       mode_sel_q, mode_sel_nxt;
  logic       blank_q, blank_nxt;
  logic       changed_q, changed_nxt;
  logic       idle_exp;

  assign f1_rise = bus.keyboard_data[5] & ~f1_prev;

`ifdef MODE_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_FRAMES);
  logic [15:0] idle_cnt;
  logic        unused_kbd;

  // Counter is held at zero outside MANUAL, which gives the clear-on-entry behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (state_q != MANUAL || bus.keyboard_data[3:0] != 4'd0) begin
      idle_cnt <= '0;
    end else if (bus.frame_start && idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign idle_exp   = (state_q == MANUAL) && (idle_cnt >= IDLE_LIMIT);
  assign unused_kbd = ^{bus.keyboard_data[7:6], bus.keyboard_data[4]};
`else
  logic unused_kbd;
  assign idle_exp   = 1'b0;
  assign unused_kbd = ^{bus.keyboard_data[7:6], bus.keyboard_data[4:0]};
`endif

  // State register; outputs are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= AUTO;
      f1_prev    <= 1'b0;
      target     <= 1'b0;
      blank_cnt  <= '0;
      mode_sel_q <= 1'b0;
      blank_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      f1_prev    <= bus.keyboard_data[5];
      target     <= target_nxt;
      blank_cnt  <= blank_cnt_nxt;
      mode_sel_q <= mode_sel_nxt;
      blank_q    <= blank_nxt;
      changed_q  <= changed_nxt;
    end
  end

  // Next state: cancel by a second press wins over a coincident frame_start.
  always_comb begin
    state_nxt  = state_q;
    target_nxt = target;
    unique case (state_q)
      AUTO: begin
        if (f1_rise) begin
          state_nxt  = PEND;
          target_nxt = 1'b1;
        end
      end
      MANUAL: begin
        if (f1_rise || idle_exp) begin
          state_nxt  = PEND;
          target_nxt = 1'b0;
        end
      end
      PEND: begin
        if (f1_rise) begin
          state_nxt = target ? AUTO : MANUAL;
        end else if (bus.frame_start) begin
          if (BLANK_FRAMES > 0) state_nxt = BLANK;
          else                  state_nxt = target ? MANUAL : AUTO;
        end
      end
      BLANK: begin
        if (bus.frame_start && blank_cnt == 8'd1) begin
          state_nxt = mode_sel_q ? MANUAL : AUTO;
        end
      end
      default: state_nxt = AUTO;
    endcase
  end

  // Output values to be registered with the next state.
  always_comb begin
    mode_sel_nxt  = mode_sel_q;
    blank_cnt_nxt = blank_cnt;
    if (state_q == PEND && !f1_rise && bus.frame_start) begin
      mode_sel_nxt  = target;
      blank_cnt_nxt = BLANK_LOAD;
    end else if (state_q == BLANK && bus.frame_start) begin
      blank_cnt_nxt = blank_cnt - 8'd1;
    end
    changed_nxt = (mode_sel_nxt != mode_sel_q);
    blank_nxt   = (state_nxt == BLANK);
  end

  assign bus.state        = state_q;
  assign bus.mode_sel     = mode_sel_q;
  assign bus.blank        = blank_q;
  assign bus.mode_changed = changed_q;

endmodule
